// File: rtl/rom_arbiter.sv
// Two-port round-robin arbiter in front of the combinational program ROM read port.
// Define ROM_ARB_FIXED_PRIO_EN to replace round-robin with fixed priority for port 0.
module rom_arbiter #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    output logic                  gnt0,
    output logic                  rvalid0,
    output logic [DATA_WIDTH-1:0] rdata0,
    input  logic                  req1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    output logic                  gnt1,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata1,
    input  logic                  lock1,
    output logic [ADDR_WIDTH-1:0] rom_address,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic                  busy
);

    logic                  last_grant_q, last_grant_d;
    logic                  lock_q, lock_d;
    logic [ADDR_WIDTH-1:0] rom_address_q, rom_address_d;
    logic                  s2_valid_q, s2_valid_d;
    logic                  s2_tag_q, s2_tag_d;
    logic                  s3_valid_q, s3_valid_d;
    logic                  s3_tag_q, s3_tag_d;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
    logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;
    logic                  gnt0_c, gnt1_c;

    // last_grant_q = 1 means port 1 was granted most recently.
    always_comb begin
        gnt0_c = 1'b0;
        gnt1_c = 1'b0;
        if (!reset) begin
            if (lock_q && req1) begin
                gnt1_c = 1'b1;
            end else if (req0 && req1) begin
`ifdef ROM_ARB_FIXED_PRIO_EN
                gnt0_c = 1'b1;
`else
                if (last_grant_q) begin
                    gnt0_c = 1'b1;
                end else begin
                    gnt1_c = 1'b1;
                end
`endif
            end else begin
                gnt0_c = req0;
                gnt1_c = req1;
            end
        end
    end

    always_comb begin
        rom_address_d = rom_address_q;
        last_grant_d  = last_grant_q;
        if (gnt0_c) begin
            rom_address_d = addr0;
            last_grant_d  = 1'b0;
        end else if (gnt1_c) begin
            rom_address_d = addr1;
            last_grant_d  = 1'b1;
        end
        lock_d     = lock1 & gnt1_c;
        s2_valid_d = gnt0_c | gnt1_c;
        s2_tag_d   = gnt1_c;
        s3_valid_d = s2_valid_q;
        s3_tag_d   = s2_tag_q;
        // rom_data reflects rom_address_q during stage 2.
        rdata0_d   = (s2_valid_q && !s2_tag_q) ? rom_data : rdata0_q;
        rdata1_d   = (s2_valid_q && s2_tag_q) ? rom_data : rdata1_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q  <= 1'b1;
            lock_q        <= 1'b0;
            rom_address_q <= '0;
            s2_valid_q    <= 1'b0;
            s2_tag_q      <= 1'b0;
            s3_valid_q    <= 1'b0;
            s3_tag_q      <= 1'b0;
            rdata0_q      <= '0;
            rdata1_q      <= '0;
        end else begin
            last_grant_q  <= last_grant_d;
            lock_q        <= lock_d;
            rom_address_q <= rom_address_d;
            s2_valid_q    <= s2_valid_d;
            s2_tag_q      <= s2_tag_d;
            s3_valid_q    <= s3_valid_d;
            s3_tag_q      <= s3_tag_d;
            rdata0_q      <= rdata0_d;
            rdata1_q      <= rdata1_d;
        end
    end

    assign gnt0        = gnt0_c;
    assign gnt1        = gnt1_c;
    assign rvalid0     = s3_valid_q & ~s3_tag_q;
    assign rvalid1     = s3_valid_q & s3_tag_q;
    assign rdata0      = rdata0_q;
    assign rdata1      = rdata1_q;
    assign rom_address = rom_address_q;
    assign busy        = s2_valid_q | s3_valid_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// Randomized bench for rom_arbiter: a read-queue reference model predicts grants, data and timing.
// The ROM is modelled as mem[x] = x[7:0] ^ 8'hA5.
module tb_rom_arbiter;

    logic        clk;
    logic        reset;
    logic        req0, req1, lock1;
    logic [11:0] addr0, addr1;
    logic        gnt0, gnt1, rvalid0, rvalid1, busy;
    logic [7:0]  rdata0, rdata1;
    logic [11:0] rom_address;
    logic [7:0]  rom_data;

    int n_checks = 0;
    int n_fail   = 0;

    rom_arbiter #(
        .ADDR_WIDTH(12),
        .DATA_WIDTH(8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req0       (req0),
        .addr0      (addr0),
        .gnt0       (gnt0),
        .rvalid0    (rvalid0),
        .rdata0     (rdata0),
        .req1       (req1),
        .addr1      (addr1),
        .gnt1       (gnt1),
        .rvalid1    (rvalid1),
        .rdata1     (rdata1),
        .lock1      (lock1),
        .rom_address(rom_address),
        .rom_data   (rom_data),
        .busy       (busy)
    );

    assign rom_data = rom_address[7:0] ^ 8'hA5;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: outstanding reads complete exactly two cycles after their grant.
    typedef struct {
        int port;
        int data;
        int due;
    } rd_t;

    rd_t pend[$];
    int  cyc      = 0;
    int  m_last   = 1;
    bit  m_lock   = 0;
    int  m_addr   = 0;
    int  m_rdata0 = 0;
    int  m_rdata1 = 0;

    task automatic step(input bit rst, input bit r0, input int a0, input bit r1, input int a1,
                        input bit l1, input bit chk);
        int  g;
        bit  erv0, erv1, ebusy;
        rd_t keep[$];
        @(negedge clk);
        reset = rst;
        req0  = r0;
        addr0 = 12'(a0);
        req1  = r1;
        addr1 = 12'(a1);
        lock1 = l1;
        #1;
        erv0  = 0;
        erv1  = 0;
        ebusy = 0;
        foreach (pend[i]) begin
            if (pend[i].due == cyc) begin
                if (pend[i].port == 0) begin
                    erv0 = 1;
                    m_rdata0 = pend[i].data;
                end else begin
                    erv1 = 1;
                    m_rdata1 = pend[i].data;
                end
            end
            if (pend[i].due == cyc || pend[i].due == cyc + 1) ebusy = 1;
        end
        g = -1;
        if (!rst) begin
            if (m_lock && r1) g = 1;
            else if (r0 && r1) begin
`ifdef ROM_ARB_FIXED_PRIO_EN
                g = 0;
`else
                g = (m_last == 1) ? 0 : 1;
`endif
            end else if (r0) g = 0;
            else if (r1) g = 1;
        end
        if (chk) begin
            check_eq("gnt0", 32'(gnt0), 32'(g == 0));
            check_eq("gnt1", 32'(gnt1), 32'(g == 1));
            check_eq("rvalid0", 32'(rvalid0), 32'(erv0));
            check_eq("rvalid1", 32'(rvalid1), 32'(erv1));
            check_eq("rdata0", 32'(rdata0), 32'(m_rdata0));
            check_eq("rdata1", 32'(rdata1), 32'(m_rdata1));
            check_eq("busy", 32'(busy), 32'(ebusy));
            check_eq("rom_address", 32'(rom_address), 32'(m_addr));
        end
        foreach (pend[i]) if (pend[i].due > cyc) keep.push_back(pend[i]);
        pend = keep;
        if (rst) begin
            pend.delete();
            m_last   = 1;
            m_lock   = 0;
            m_addr   = 0;
            m_rdata0 = 0;
            m_rdata1 = 0;
        end else begin
            m_lock = l1 && (g == 1);
            if (g >= 0) begin
                rd_t e;
                m_last = g;
                m_addr = (g == 0) ? a0 : a1;
                e.port = g;
                e.data = (m_addr & 'hFF) ^ 'hA5;
                e.due  = cyc + 2;
                pend.push_back(e);
            end
        end
        cyc++;
    endtask

    initial begin
        reset = 1'b1;
        req0  = 1'b0;
        req1  = 1'b0;
        lock1 = 1'b0;
        addr0 = '0;
        addr1 = '0;
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1);

        // Single read on port 0.
        step(0, 1, 'h010, 0, 0, 0, 1);
        check_eq("single_gnt0", 32'(gnt0), 32'd1);
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        check_eq("single_rvalid0", 32'(rvalid0), 32'd1);
        check_eq("single_rdata0", 32'(rdata0), 32'hB5);
        step(0, 0, 0, 0, 0, 0, 1);

        // Conflicts held four cycles.
        repeat (4) step(0, 1, 'h001, 1, 'h002, 0, 1);
        repeat (3) step(0, 0, 0, 0, 0, 0, 1);

        // Lock held by port 1, released on its last grant.
        step(0, 0, 0, 1, 'h020, 1, 1);
        step(0, 1, 'h030, 1, 'h021, 1, 1);
        check_eq("lock_gnt0_low", 32'(gnt0), 32'd0);
        step(0, 1, 'h030, 1, 'h022, 0, 1);
        check_eq("lock_gnt0_low2", 32'(gnt0), 32'd0);
        step(0, 1, 'h030, 1, 'h023, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        repeat (2) step(0, 0, 0, 0, 0, 0, 1);

        // Address extremes.
        step(0, 1, 'hFFF, 0, 0, 0, 1);
        step(0, 1, 'h000, 0, 0, 0, 1);
        check_eq("ext_addr_fff", 32'(rom_address), 32'hFFF);
        step(0, 0, 0, 0, 0, 0, 1);
        check_eq("ext_addr_000", 32'(rom_address), 32'h000);
        check_eq("ext_rdata_5a", 32'(rdata0), 32'h5A);
        step(0, 0, 0, 0, 0, 0, 1);
        check_eq("ext_rdata_a5", 32'(rdata0), 32'hA5);

        // Reset while a port 1 read is in flight.
        step(0, 0, 0, 1, 'h055, 0, 1);
        step(1, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        check_eq("rst_rvalid1", 32'(rvalid1), 32'd0);
        check_eq("rst_rdata1", 32'(rdata1), 32'd0);
        step(0, 1, 'h007, 1, 'h008, 0, 1);
        check_eq("rst_conflict_gnt0", 32'(gnt0), 32'd1);

        // Randomized traffic with occasional lock and reset.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) != 0), $urandom_range(0, 4095),
                 ($urandom_range(0, 2) != 0), $urandom_range(0, 4095),
                 ($urandom_range(0, 3) == 0), 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
